instr_fetch_buffer: RTL and testbench

- Consumer side of the 6-bit program-counter interface.
- Accepts PC addresses over a valid/ready handshake and reads the instruction word from an internal synchronous program memory.
- Buffers returned words, tagged with their PC, in a small in-order FIFO feeding the decoder over a second valid/ready handshake.
- Supports a single-cycle flush for branch redirects and a program-load write port for testbench/boot loading.

---
 rtl/instr_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: accepts PC requests over valid/ready, reads a synchronous
// program memory and queues {word, pc} in an in-order FIFO for the decoder.
// Single-cycle flush drops buffered and in-flight fetches.
// Optional: define IFETCH_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of cycles where the decoder is ready but starved.
module instr_fetch_buffer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            pc_addr,
    input  logic                         pc_valid,
    output logic                         pc_ready,
    input  logic                         flush,
    input  logic                         prog_we,
    input  logic [ADDR_W-1:0]            prog_addr,
    input  logic [DATA_W-1:0]            prog_data,
    output logic [DATA_W-1:0]            instr_data,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // p1: word read from memory plus the PC it belongs to
    logic              vld_p1;
    logic [DATA_W-1:0] word_p1;
    logic [ADDR_W-1:0] pc_p1;

    // p2: FIFO storage; the head is mirrored into the registered outputs
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              accept;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    demand;
    logic [CNT_W-1:0]  occ_after_pop;
    logic [CNT_W-1:0]  occ_next;
    logic [PTR_W-1:0]  rd_next;

`ifdef IFETCH_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Space check counts the in-flight word and credits a pop happening now.
    assign demand   = (CNT_W+1)'(occupancy) + (CNT_W+1)'(vld_p1)
                    - (CNT_W+1)'(instr_valid & instr_ready);
    assign pc_ready = !rst && !flush && (demand < (CNT_W+1)'(DEPTH));

    assign accept        = pc_valid & pc_ready;
    assign push          = vld_p1 & !flush;
    assign pop           = instr_valid & instr_ready & !flush;
    assign occ_after_pop = occupancy - CNT_W'(pop);
    assign occ_next      = occ_after_pop + CNT_W'(push);
    assign rd_next       = rd_ptr + PTR_W'(pop);

    // p0 -> p1: program memory, write port and read-before-write sync read
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
        if (accept) begin
            word_p1 <= mem[pc_addr];
            pc_p1   <= pc_addr;
        end
    end

    // In-flight flag: set by an accept, otherwise cleared after the return edge
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (flush)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept;
    end

    // p1 -> p2: returned word is written at the FIFO tail
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= word_p1;
            fifo_pc[wr_ptr]   <= pc_p1;
        end
    end

    // FIFO control and registered head outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr      <= rd_next;
            occupancy   <= occ_next;
            instr_valid <= (occ_next != '0);
            // Empty-after-pop FIFO receiving a push: the new word bypasses to the head
            if (push && (occ_after_pop == '0)) begin
                instr_data <= word_p1;
                instr_pc   <= pc_p1;
            end else if (occ_after_pop != '0) begin
                instr_data <= fifo_data[rd_next];
                instr_pc   <= fifo_pc[rd_next];
            end
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    // Decoder-starved cycle counter; survives flush, cleared by reset only
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (instr_ready && !instr_valid)
            stall_cnt <= sat_inc16(stall_cnt);
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_buffer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        occupancy;
`ifdef IFETCH_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    instr_fetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .occupancy   (occupancy)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit                model_on = 1'b0;
    logic [DATA_W-1:0] mem_m [2**ADDR_W];
    ent_t              q[$];
    int                infl = 0;
    ent_t              infl_e;
    logic [15:0]       exp_stall = '0;
    ent_t              popped[$];
    ent_t              exp_l[$];

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge clk) begin
        int  pop_m;
        bit  exp_ready;
        if (model_on) begin
            pop_m     = (q.size() > 0 && instr_ready) ? 1 : 0;
            exp_ready = !rst && !flush && ((q.size() + infl - pop_m) < DEPTH);
            chk("pc_ready", 64'(pc_ready), 64'(exp_ready));
            chk("instr_valid", 64'(instr_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            if (q.size() > 0) begin
                chk("instr_data", 64'(instr_data), 64'(q[0].data));
                chk("instr_pc", 64'(instr_pc), 64'(q[0].pc));
            end
`ifdef IFETCH_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (rst)
                exp_stall = '0;
            else if (instr_ready && q.size() == 0 && exp_stall != 16'hFFFF)
                exp_stall = exp_stall + 16'd1;
`endif
            if (!rst && !flush && instr_valid && instr_ready)
                popped.push_back(ent_t'{instr_pc, instr_data});

            if (rst || flush) begin
                q.delete();
                infl = 0;
            end else begin
                if (pop_m != 0)
                    void'(q.pop_front());
                if (infl != 0)
                    q.push_back(infl_e);
                if (pc_valid && exp_ready) begin
                    infl   = 1;
                    infl_e = ent_t'{pc_addr, mem_m[pc_addr]};
                end else begin
                    infl = 0;
                end
            end
            if (prog_we)
                mem_m[prog_addr] = prog_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded)
    task automatic do_req(input logic [ADDR_W-1:0] a);
        bit done = 1'b0;
        pc_valid = 1'b1;
        pc_addr  = a;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            done = pc_ready;
            step();
        end
        chk("req_accepted", 64'(done), 64'd1);
    endtask

    task automatic prog(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic expect_ent(input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] d);
        exp_l.push_back(ent_t'{p, d});
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, 64'(popped.size()), 64'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++) begin
            if (i < popped.size()) begin
                chk({nm, "_data"}, 64'(popped[i].data), 64'(exp_l[i].data));
                chk({nm, "_pc"}, 64'(popped[i].pc), 64'(exp_l[i].pc));
            end
        end
        exp_l.delete();
        popped.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] init4 [4];
        logic [15:0]       stall_snap;
        bit                pend;
        init4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        rst = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0; instr_ready = 1'b0;
        stall_snap = '0;
        step();
        step();
        model_on = 1'b1;

        // 1: load memory while in reset, then release
        for (int i = 0; i < 2**ADDR_W; i++)
            prog(6'(i), (i < 4) ? init4[i] : $urandom);
        chk("rst_pc_ready", 64'(pc_ready), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_instr_data", 64'(instr_data), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("release_pc_ready", 64'(pc_ready), 64'd1);
        step();

        // 2: back-to-back fetch, two-cycle latency, no bubbles
        instr_ready = 1'b1;
        popped.delete();
        do_req(6'd0);
        chk("t2_lat_valid0", 64'(instr_valid), 64'd0);
        do_req(6'd1);
        chk("t2_valid1", 64'(instr_valid), 64'd1);
        chk("t2_data1", 64'(instr_data), 64'h11);
        do_req(6'd2);
        chk("t2_data2", 64'(instr_data), 64'h22);
        do_req(6'd3);
        chk("t2_data3", 64'(instr_data), 64'h33);
        pc_valid = 1'b0;
        step();
        chk("t2_data4", 64'(instr_data), 64'h44);
        chk("t2_pc4", 64'(instr_pc), 64'd3);
        step();
        chk("t2_drained", 64'(instr_valid), 64'd0);
        step();
        expect_ent(6'd0, 32'h11); expect_ent(6'd1, 32'h22);
        expect_ent(6'd2, 32'h33); expect_ent(6'd3, 32'h44);
        check_log("t2_log");

        // 3: backpressure fills the FIFO, then drains in order
        instr_ready = 1'b0;
`ifdef IFETCH_STALL_CNT_EN
        stall_snap = stall_cnt;
`endif
        do_req(6'd0);
        do_req(6'd1);
        pc_addr = 6'd2;
        #1;
        chk("t3_ready_low", 64'(pc_ready), 64'd0);
        step();
        chk("t3_occ_full", 64'(occupancy), 64'd2);
        repeat (3) step();
        chk("t3_hold_data", 64'(instr_data), 64'h11);
        chk("t3_hold_pc", 64'(instr_pc), 64'd0);
        chk("t3_hold_ready", 64'(pc_ready), 64'd0);
`ifdef IFETCH_STALL_CNT_EN
        chk("t3_stall_hold", 64'(stall_cnt), 64'(stall_snap));
`endif
        instr_ready = 1'b1;
        do_req(6'd2);
        pc_valid = 1'b0;
        repeat (5) step();
        expect_ent(6'd0, 32'h11); expect_ent(6'd1, 32'h22); expect_ent(6'd2, 32'h33);
        check_log("t3_log");

        // 4: flush with one buffered and one in flight
        instr_ready = 1'b0;
        do_req(6'd0);
        do_req(6'd1);
        pc_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("t4_flush_ready", 64'(pc_ready), 64'd0);
        step();
        flush = 1'b0;
        chk("t4_valid_after", 64'(instr_valid), 64'd0);
        chk("t4_occ_after", 64'(occupancy), 64'd0);
        popped.delete();
        instr_ready = 1'b1;
        repeat (3) step();
        chk("t4_no_ghost", 64'(instr_valid), 64'd0);
        do_req(6'd3);
        pc_valid = 1'b0;
        repeat (4) step();
        expect_ent(6'd3, 32'h44);
        check_log("t4_log");

        // 5: top address
        prog(6'd63, 32'hDEADBEEF);
        popped.delete();
        do_req(6'd63);
        do_req(6'd0);
        pc_valid = 1'b0;
        repeat (4) step();
        expect_ent(6'd63, 32'hDEADBEEF); expect_ent(6'd0, 32'h11);
        check_log("t5_log");

        // 6: read-before-write on the accept edge
        prog(6'd5, 32'h55);
        popped.delete();
        prog_we = 1'b1; prog_addr = 6'd5; prog_data = 32'hAA;
        pc_valid = 1'b1; pc_addr = 6'd5;
        #1;
        chk("t6_ready", 64'(pc_ready), 64'd1);
        step();
        prog_we = 1'b0;
        pc_valid = 1'b0;
        repeat (3) step();
        do_req(6'd5);
        pc_valid = 1'b0;
        repeat (4) step();
        expect_ent(6'd5, 32'h55); expect_ent(6'd5, 32'hAA);
        check_log("t6_log");

        // Random traffic against the model
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            instr_ready = ($urandom_range(0, 99) < ((c < 1500) ? 85 : 40));
            prog_we     = ($urandom_range(0, 15) == 0);
            prog_addr   = 6'($urandom);
            prog_data   = $urandom;
            if (!pend) begin
                pc_valid = ($urandom_range(0, 2) != 0);
                pc_addr  = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom);
            end
            #1;
            pend = pc_valid && !pc_ready;
            step();
        end
        rst = 1'b0; flush = 1'b0; pc_valid = 1'b0; prog_we = 1'b0; instr_ready = 1'b1;
        repeat (5) step();
        popped.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
